rr_arbiter_fsm: RTL and testbench
=================================

Name: rr_arbiter_fsm

Overview:
Parametrised N-requester round-robin arbiter. It is the multi-channel successor to the two-requester IDLE/GNT0/GNT1 grant FSM and sits in front of shared resources such as a bus, memory port or shared engine. Grants are registered and one-hot. An owner keeps its grant while its request stays high. When the owner releases, the grant hands off to the next requester with no idle gap. Fairness comes from a rotating priority pointer.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
ID_W, 2, width of gnt_id; must be max(1, clog2(NUM_REQ))
MAX_HOLD, 16, maximum grant hold cycles when the hold limit is compiled in (>=2)

Ports:
clock  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  request vector; bit i = requester i
gnt  output  NUM_REQ  registered one-hot grant; all zero when idle
gnt_valid  output  1  registered; equals OR of gnt
gnt_id  output  ID_W  registered index of the granted requester; holds its last value when idle
hold_cnt  output  clog2(MAX_HOLD)+1  registered count of cycles the current owner has held the grant

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, state=IDLE, ptr=0. Requester 0 has highest priority after reset.
- States: IDLE, GRANT. Internal state: ptr (ID_W bits) and owner (ID_W bits).
- Winner selection (combinational): first i with req[i]=1, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1. Search wraps modulo NUM_REQ.
- IDLE:
  - req==0: stay in IDLE; outputs stay zero.
  - Any req set: go to GRANT with owner=winner; gnt[winner]=1 on the next edge.
  - Latency: 1 cycle from sampled request to visible grant.
- GRANT, req[owner]=1: stay in GRANT; gnt is unchanged; hold_cnt increments and saturates at all-ones.
- GRANT, req[owner]=0, other requests pending:
  - Direct handoff: the new winner's gnt bit rises on the same edge the old bit falls; no idle cycle.
  - Winner search excludes the old owner.
  - hold_cnt resets to 0.
- GRANT, req[owner]=0, no other request: go to IDLE; gnt clears on the next edge.
- ptr update: set to (winner+1) mod NUM_REQ on every new grant. It does not change while a grant is held.
- gnt is never multi-hot, and gnt_valid never disagrees with gnt.
- Requests that toggle on non-owner lines during a held grant have no effect.
- Reset asserted mid-grant: all outputs return to reset values on that edge. Reset dominates every other event.
- NUM_REQ=1: winner is always 0; gnt equals req delayed by 1 cycle.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined:
  - In GRANT, when hold_cnt reaches MAX_HOLD-1 and another requester is pending, force rotation even if req[owner]=1. The next winner (old owner excluded) is granted on the next edge and hold_cnt resets.
  - If no other requester is pending, the owner keeps the grant and hold_cnt saturates.
  - The preempted requester re-enters arbitration as a normal requester.
- Undefined: no hold limit; an owner holds the grant indefinitely. hold_cnt still counts (debug only).

Test Plan:
- Reset priority: NUM_REQ=4; after reset, req=4'b1111 for 1 cycle then held -> gnt=4'b0001, gnt_id=0 one cycle later; ptr=1.
- Rotation and handoff: req=4'b1111, each owner drops its request 3 cycles after its grant -> gnt sequence 0001, 0010, 0100, 1000, 0001 with no zero cycle between grants.
- Wrap-around: ptr=3 (grant 2 just released), req=4'b0011 -> gnt=4'b0001, gnt_id=0, ptr=1.
- Release to idle: single req[2] pulse of 5 cycles -> gnt=4'b0100 for 5 cycles starting 1 cycle after rise; then gnt=0 and gnt_valid=0; gnt_id stays 2.
- Reset mid-grant: gnt=4'b1000 held; assert reset for 1 cycle -> gnt=0, gnt_id=0, hold_cnt=0 after that edge. With req=4'b1000 still high, regrant 4'b1000 one cycle after reset deasserts.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=16): req[0] held high, req[1] rises at cycle 2 -> gnt switches from 0001 to 0010 after exactly 16 grant cycles. With req[1] absent, gnt=0001 persists for more than 40 cycles.

Source files
------------

// File: rtl/rr_arbiter_fsm.sv
`default_nettype none
// rr_arbiter_fsm: N-requester round-robin arbiter, registered one-hot grant, direct handoff (rev 1.0).
// Optional hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter_fsm #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          gnt_valid,
  output logic [ID_W-1:0]               gnt_id,
  output logic [$clog2(MAX_HOLD):0]     hold_cnt
);

  localparam int HC_W = $clog2(MAX_HOLD) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [ID_W-1:0]    ptr_q,       ptr_d;
  logic [ID_W-1:0]    owner_q,     owner_d;
  logic [NUM_REQ-1:0] gnt_q,       gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [HC_W-1:0]    hold_cnt_q,  hold_cnt_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] cand;
  logic               owner_req;
  logic               force_rot;
  logic               found_hi, found_lo, win_any;
  logic [ID_W-1:0]    win_hi, win_lo, winner, winner_next;

  assign owner_oh  = NUM_REQ'(1) << owner_q;
  assign others    = req & ~owner_oh;
  assign owner_req = |(req & owner_oh);
  // From IDLE every request competes; from GRANT the departing owner is excluded.
  assign cand      = (state_q == ST_IDLE) ? req : others;

`ifdef ARB_HOLD_LIMIT_EN
  assign force_rot = (state_q == ST_GRANT) && (|others) &&
                     (hold_cnt_q >= HC_W'(MAX_HOLD - 1));
`else
  assign force_rot = 1'b0;
`endif

  // Rotating priority: lowest candidate at or above ptr wins, else lowest below ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        if (i >= int'(ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = ID_W'(i);
        end else begin
          found_lo = 1'b1;
          win_lo   = ID_W'(i);
        end
      end
    end
    win_any     = found_hi | found_lo;
    winner      = found_hi ? win_hi : win_lo;
    winner_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d     = ST_GRANT;
          owner_d     = winner;
          ptr_d       = winner_next;
          gnt_d       = NUM_REQ'(1) << winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (owner_req && !force_rot) begin
          hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HC_W'(1);
        end else if (win_any) begin
          owner_d     = winner;
          ptr_d       = winner_next;
          gnt_d       = NUM_REQ'(1) << winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = owner_q;
  assign hold_cnt  = hold_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_fsm.sv
`default_nettype none
// tb_rr_arbiter_fsm: scoreboard bench; a behavioural model queues expected outputs, a monitor compares.
module tb_rr_arbiter_fsm;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int MAX_HOLD = 16;
  localparam int HCW      = $clog2(MAX_HOLD) + 1;
  localparam int HC_MAX   = (1 << HCW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IW-1:0]  gnt_id;
  logic [HCW-1:0] hold_cnt;

  rr_arbiter_fsm #(.NUM_REQ(N), .ID_W(IW), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .hold_cnt  (hold_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic           valid;
    logic [IW-1:0]  id;
    logic [HCW-1:0] hc;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  // Reference model state: owner < 0 means idle.
  int m_owner = -1;
  int m_id    = 0;
  int m_ptr   = 0;
  int m_hc    = 0;
  bit m_limit;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_owner = w;
    m_id    = w;
    m_ptr   = (w + 1) % N;
    m_hc    = 0;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] rq);
    logic [N-1:0] oth;
    bit           frc;
    if (r) begin
      m_owner = -1; m_id = 0; m_ptr = 0; m_hc = 0;
    end else if (m_owner < 0) begin
      if (rq != 0) grant_to(pick(rq, m_ptr));
    end else begin
      oth = rq;
      oth[m_owner] = 1'b0;
      frc = m_limit && (m_hc >= MAX_HOLD - 1) && (oth != 0);
      if (rq[m_owner] && !frc) begin
        if (m_hc < HC_MAX) m_hc++;
      end else if (oth != 0) begin
        grant_to(pick(oth, m_ptr));
      end else begin
        m_owner = -1;
        m_hc    = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] rq);
    exp_t e;
    reset = r;
    req   = rq;
    model_step(r, rq);
    e.gnt   = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.valid = (m_owner >= 0);
    e.id    = IW'(m_id);
    e.hc    = HCW'(m_hc);
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: outputs are presented every cycle; compare after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || hold_cnt !== e.hc) begin
          failed++;
          $display("FAIL outputs cyc=%0d: got gnt=%b v=%b id=%0d hc=%0d, expected gnt=%b v=%b id=%0d hc=%0d",
                   cyc, gnt, gnt_valid, gnt_id, hold_cnt, e.gnt, e.valid, e.id, e.hc);
        end
        tests++;
        if (!$onehot0(gnt) || (gnt_valid !== (|gnt))) begin
          failed++;
          $display("FAIL onehot cyc=%0d: got gnt=%b valid=%b, expected one-hot-or-zero with valid=|gnt",
                   cyc, gnt, gnt_valid);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
`ifdef ARB_HOLD_LIMIT_EN
    m_limit = 1'b1;
`else
    m_limit = 1'b0;
`endif
    // Reset, then requester 0 wins first.
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    cycle(1'b0, '0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1111);

    // Rotation: each owner holds 3 cycles then drops for one cycle.
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1111);
      r = 4'b1111;
      r[m_id] = 1'b0;
      cycle(1'b0, r);
    end

    // Wrap-around: release grant 2 so ptr=3, then only 0 and 1 request.
    cycle(1'b1, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0011);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0);

    // Release to idle after a 5-cycle pulse.
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0100);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0);

    // Reset mid-grant, then regrant.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1000);
    cycle(1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1000);

    // Long hold: counter saturation, then a competitor appears.
    cycle(1'b1, '0);
    for (int i = 0; i < 45; i++) cycle(1'b0, 4'b0001);
    for (int i = 0; i < 25; i++) cycle(1'b0, 4'b0011);
    cycle(1'b1, '0);
    cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b0001);
    for (int i = 0; i < 30; i++) cycle(1'b0, 4'b0011);

    // Random: sticky requests with occasional flips and rare resets.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      cycle(($urandom_range(0, 299) == 0), r);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
